ram_byte_ctrl: RTL and testbench

- Initiator for the on-board byte-wide synchronous RAM.
- Converts 8/16/32-bit load/store requests from the CPU LSU/ifetch arbiter into sequential byte transactions on the RAM's enable, read-not-write, address and data bus.
- Assembles read bytes into a little-endian word and returns a single response.
- Sits between the memory arbiter and the RAM instance.

---
 rtl/ram_byte_ctrl_pkg.sv | 27 ++
 rtl/ram_byte_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ram_byte_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_byte_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM initiator.
// Contents: request size codes, controller state enum, size -> byte-count helper.
// Ports: none (package).
package ram_byte_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_READ_TAIL,
    ST_RESP
  } state_t;

  // Size code 2'b11 is handled as a word access.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_ctrl.sv
// Byte-serial initiator for a byte-wide synchronous RAM: splits 8/16/32-bit
// loads/stores into byte cycles and returns one response per request.
// Ports: clk_in/rst_in; req_* valid/ready request side; resp_* one-cycle
// response; mem_* RAM enable, read-not-write, address and data buses.
module ram_byte_ctrl
  import ram_byte_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [1:0]            req_size_in,
  input  logic [31:0]           req_addr_in,
  input  logic [31:0]           req_wdata_in,
  output logic                  resp_valid_out,
  output logic [31:0]           resp_rdata_out,
  output logic                  mem_en_out,
  output logic                  mem_r_nw_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic [7:0]            mem_d_out,
  input  logic [7:0]            mem_d_in
);

  // Control state runs one cycle ahead of the bus: the registered bus outputs
  // for byte i are computed while state_q sits in that byte's slot.
  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            len_q, len_d;
  logic                  we_q, we_d;
  logic [31:0]           asm_q, asm_d;
  // Index of the read byte currently presented on the bus (N during the tail).
  logic [2:0]            bidx_q, bidx_d;

  logic                  mem_en_q, mem_en_d;
  logic                  mem_r_nw_q, mem_r_nw_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_d_q, mem_d_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            cap_lane;
  logic                  last_byte;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^req_addr_in[31:ADDR_WIDTH];

  assign cur_addr  = base_q + ADDR_WIDTH'(idx_q);   // wraps modulo 2^ADDR_WIDTH
  assign cap_lane  = 2'(bidx_q - 3'd1);
  assign last_byte = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    len_d        = len_q;
    we_d         = we_q;
    asm_d        = asm_q;
    bidx_d       = bidx_q;
    mem_en_d     = 1'b0;
    mem_r_nw_d   = 1'b1;
    mem_a_d      = mem_a_q;
    mem_d_d      = mem_d_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;

    // RAM data for byte k is valid in the bus cycle after its address, so
    // the byte ending now belongs to the address one slot earlier.
    if (mem_en_q && mem_r_nw_q && (bidx_q != 3'd0)) begin
      asm_d[{cap_lane, 3'b000} +: 8] = mem_d_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          state_d = req_we_in ? ST_WRITE : ST_READ;
          idx_d   = 2'd0;
          base_d  = req_addr_in[ADDR_WIDTH-1:0];
          wdata_d = req_wdata_in;
          len_d   = size_to_len(req_size_in);
          we_d    = req_we_in;
          asm_d   = '0;
        end
      end
      ST_WRITE: begin
        mem_en_d   = 1'b1;
        mem_r_nw_d = 1'b0;
        mem_a_d    = cur_addr;
        mem_d_d    = wdata_q[{idx_q, 3'b000} +: 8];
        if (last_byte) state_d = ST_RESP;
        else           idx_d   = idx_q + 2'd1;
      end
      ST_READ: begin
        mem_en_d = 1'b1;
        mem_a_d  = cur_addr;
        bidx_d   = {1'b0, idx_q};
        if (last_byte) state_d = ST_READ_TAIL;
        else           idx_d   = idx_q + 2'd1;
      end
      ST_READ_TAIL: begin
        // Keep enable and address so the RAM still drives the last byte.
        mem_en_d = 1'b1;
        bidx_d   = len_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        // The bus is in its tail cycle now; asm_d already holds the last lane.
        resp_valid_d = 1'b1;
        if (!we_q) resp_rdata_d = asm_d;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      len_q        <= '0;
      we_q         <= 1'b0;
      asm_q        <= '0;
      bidx_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_r_nw_q   <= 1'b1;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      len_q        <= len_d;
      we_q         <= we_d;
      asm_q        <= asm_d;
      bidx_q       <= bidx_d;
      mem_en_q     <= mem_en_d;
      mem_r_nw_q   <= mem_r_nw_d;
      mem_a_q      <= mem_a_d;
      mem_d_q      <= mem_d_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready_out  = (state_q == ST_IDLE);
  assign resp_valid_out = resp_valid_q;
  assign resp_rdata_out = resp_rdata_q;
  assign mem_en_out     = mem_en_q;
  assign mem_r_nw_out   = mem_r_nw_q;
  assign mem_a_out      = mem_a_q;
  assign mem_d_out      = mem_d_q;

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Bench for ram_byte_ctrl with a behavioural byte-wide synchronous RAM.
// Table of directed requests plus hand-written queued-request and
// mid-operation reset sequences.
module tb_ram_byte_ctrl;

  localparam int AW = 17;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          req_valid_in;
  logic          req_ready_out;
  logic          req_we_in;
  logic [1:0]    req_size_in;
  logic [31:0]   req_addr_in;
  logic [31:0]   req_wdata_in;
  logic          resp_valid_out;
  logic [31:0]   resp_rdata_out;
  logic          mem_en_out;
  logic          mem_r_nw_out;
  logic [AW-1:0] mem_a_out;
  logic [7:0]    mem_d_out;
  logic [7:0]    mem_d_in;

  always #5 clk_in = ~clk_in;

  ram_byte_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_we_in      (req_we_in),
    .req_size_in    (req_size_in),
    .req_addr_in    (req_addr_in),
    .req_wdata_in   (req_wdata_in),
    .resp_valid_out (resp_valid_out),
    .resp_rdata_out (resp_rdata_out),
    .mem_en_out     (mem_en_out),
    .mem_r_nw_out   (mem_r_nw_out),
    .mem_a_out      (mem_a_out),
    .mem_d_out      (mem_d_out),
    .mem_d_in       (mem_d_in)
  );

  // Synchronous byte RAM: address sampled at the clock edge, data driven the
  // following cycle, output gated by enable.
  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] ram_rd_q = 8'h00;
  always @(posedge clk_in) begin
    if (mem_en_out) begin
      if (!mem_r_nw_out) ram[mem_a_out] <= mem_d_out;
      else               ram_rd_q <= ram[mem_a_out];
    end
  end
  assign mem_d_in = mem_en_out ? ram_rd_q : 8'h00;

  int en_cnt   = 0;
  int wr_cnt   = 0;
  int resp_cnt = 0;
  always @(negedge clk_in) begin
    if (mem_en_out) en_cnt++;
    if (mem_en_out && !mem_r_nw_out) wr_cnt++;
    if (resp_valid_out) resp_cnt++;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_req(input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat);
    int w;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_we_in    = we;
    req_size_in  = size;
    req_addr_in  = addr;
    req_wdata_in = wdata;
    w = 0;
    while (!req_ready_out && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
    en_cnt = 0;
    wr_cnt = 0;
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!resp_valid_out && lat < 20);
    rdata = resp_rdata_out;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_en;
    int          exp_wr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rdata;
    int          lat;
    int          lowcnt;
    int          resp_base;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h1FFFF] = 8'hAB;
    ram[17'h00200] = 8'h11;
    ram[17'h00201] = 8'h22;
    ram[17'h00202] = 8'h33;
    ram[17'h00203] = 8'h44;

    vecs[0] = '{"st_word",   1'b1, 2'b10, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 5, 4, 4};
    vecs[1] = '{"ld_word",   1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h1234_5678, 6, 5, 0};
    vecs[2] = '{"ld_byte",   1'b0, 2'b00, 32'h0001_FFFF, 32'h0,         32'h0000_00AB, 3, 2, 0};
    vecs[3] = '{"st_half",   1'b1, 2'b01, 32'h0001_FFFF, 32'hCAFE_BEEF, 32'h0000_00AB, 3, 2, 2};
    vecs[4] = '{"ld_half",   1'b0, 2'b01, 32'h0001_FFFF, 32'h0,         32'h0000_BEEF, 4, 3, 0};
    vecs[5] = '{"ld_size11", 1'b0, 2'b11, 32'h0000_0200, 32'h0,         32'h4433_2211, 6, 5, 0};
    vecs[6] = '{"ld_trunc",  1'b0, 2'b10, 32'hFFFE_0100, 32'h0,         32'h1234_5678, 6, 5, 0};

    rst_in       = 1'b1;
    req_valid_in = 1'b0;
    req_we_in    = 1'b0;
    req_size_in  = 2'b00;
    req_addr_in  = '0;
    req_wdata_in = '0;
    repeat (2) @(negedge clk_in);
    check("rst_ready", {31'd0, req_ready_out}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    check("rst_rdata", resp_rdata_out, 32'd0);
    check("rst_en", {31'd0, mem_en_out}, 32'd0);
    check("rst_r_nw", {31'd0, mem_r_nw_out}, 32'd1);
    check("rst_addr", 32'(mem_a_out), 32'd0);
    check("rst_dout", 32'(mem_d_out), 32'd0);
    rst_in = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rdata, lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_en_cycles"}, 32'(en_cnt), 32'(vecs[i].exp_en));
      check({vecs[i].name, "_wr_cycles"}, 32'(wr_cnt), 32'(vecs[i].exp_wr));
    end
    check("ram_100", 32'(ram[17'h00100]), 32'h78);
    check("ram_101", 32'(ram[17'h00101]), 32'h56);
    check("ram_102", 32'(ram[17'h00102]), 32'h34);
    check("ram_103", 32'(ram[17'h00103]), 32'h12);
    check("ram_1ffff", 32'(ram[17'h1FFFF]), 32'hEF);
    check("ram_00000_wrap", 32'(ram[17'h00000]), 32'hBE);
    check("ram_00001_untouched", 32'(ram[17'h00001]), 32'h00);

    // Two queued requests with valid held high throughout.
    @(negedge clk_in);
    resp_base    = resp_cnt;
    req_valid_in = 1'b1;
    req_we_in    = 1'b1;
    req_size_in  = 2'b00;
    req_addr_in  = 32'h10;
    req_wdata_in = 32'h0000_005A;
    @(posedge clk_in);
    #1;
    en_cnt    = 0;
    wr_cnt    = 0;
    req_we_in = 1'b0;
    lowcnt    = 0;
    while (!req_ready_out && lowcnt < 20) begin
      lowcnt++;
      @(posedge clk_in);
      #1;
    end
    check("queue_ready_low_cycles", 32'(lowcnt), 32'd2);
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!resp_valid_out && lat < 20);
    check("queue_ld_lat", 32'(lat), 32'd3);
    check("queue_ld_rdata", resp_rdata_out, 32'h0000_005A);
    @(negedge clk_in);
    check("queue_resp_count", 32'(resp_cnt - resp_base), 32'd2);
    check("queue_en_cycles", 32'(en_cnt), 32'd3);
    check("queue_wr_cycles", 32'(wr_cnt), 32'd1);

    // Reset while a word load is on the bus.
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_we_in    = 1'b0;
    req_size_in  = 2'b10;
    req_addr_in  = 32'h100;
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #3;
    check("midrd_en_before_rst", {31'd0, mem_en_out}, 32'd1);
    rst_in = 1'b1;
    #1;
    check("midrd_rst_en", {31'd0, mem_en_out}, 32'd0);
    check("midrd_rst_r_nw", {31'd0, mem_r_nw_out}, 32'd1);
    check("midrd_rst_addr", 32'(mem_a_out), 32'd0);
    check("midrd_rst_dout", 32'(mem_d_out), 32'd0);
    check("midrd_rst_rdata", resp_rdata_out, 32'd0);
    check("midrd_rst_ready", {31'd0, req_ready_out}, 32'd1);
    resp_base = resp_cnt;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (8) @(negedge clk_in);
    check("midrd_no_resp", 32'(resp_cnt - resp_base), 32'd0);
    run_req(1'b0, 2'b10, 32'h100, 32'h0, rdata, lat);
    check("post_rst_ld_lat", 32'(lat), 32'd6);
    check("post_rst_ld_rdata", rdata, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
